// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                    |
// | Brief    : UART transmitter with baud divider, optional parity and an      |
// |            input FIFO; queued frames are sent back-to-back.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
    parameter int CLK_DIV    = 64,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data_i,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_idle,
    output logic                          tx_bits_ok,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_bw = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_bw-1:0] c_baud_last = c_bw'(CLK_DIV - 1);
    localparam logic [c_bw-1:0] c_baud_pre  = c_bw'(CLK_DIV - 2);
    localparam logic [3:0]      c_data_last = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_stop_last = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw:0]        r_wr_ptr;
    logic [c_aw:0]        r_rd_ptr;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_push     = tx_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr[c_aw-1:0]];
    assign fifo_count = r_wr_ptr - r_rd_ptr;
    assign tx_ready   = !w_full;

    // Storage is not reset; the pointers alone define what is queued.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= tx_data_i;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [c_bw-1:0]      r_baud;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_txd;
    logic                 r_bits_ok;

    logic                 w_baud_end;
    logic                 w_stop_last;
    logic                 w_par_bit;

    assign w_baud_end  = (r_baud == c_baud_last);
    assign w_stop_last = (r_bit == c_stop_last);
    assign w_par_bit   = (PARITY == 1) ? ~r_par : r_par;

    // A pop happens from IDLE or exactly at the end of the final stop bit.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_STOP) && w_baud_end && w_stop_last));

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_txd     <= 1'b1;
            r_bits_ok <= 1'b0;
        end else begin
            r_bits_ok <= 1'b0;
            if (r_state != S_IDLE) begin
                r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                end

                S_START: begin
                    if (w_baud_end) begin
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_baud_end) begin
                        if (r_bit == c_data_last) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                r_txd   <= w_par_bit;
                                r_state <= S_PARITY;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_txd   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end

                S_PARITY: begin
                    if (w_baud_end) begin
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                    end
                end

                S_STOP: begin
                    // Registered pulse lands on the final cycle of the last stop bit.
                    if (w_stop_last && (r_baud == c_baud_pre)) begin
                        r_bits_ok <= 1'b1;
                    end
                    if (w_baud_end) begin
                        if (w_stop_last) begin
                            r_bit   <= '0;
                            r_txd   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end

                default: begin
                    r_txd   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase

            // Loading a new frame overrides whatever the state above chose.
            if (w_pop) begin
                r_shift <= w_head;
                r_par   <= ^w_head;
                r_baud  <= '0;
                r_bit   <= '0;
                r_txd   <= 1'b0;
                r_state <= S_START;
            end
        end
    end

    assign txd        = r_txd;
    assign tx_bits_ok = r_bits_ok;
    assign tx_idle    = (r_state == S_IDLE) && w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_fifo                                                 |
// | Brief    : Four differently parameterised uart_tx_fifo instances against a |
// |            frame-level reference model.                                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

    localparam int c_n = 4;
    localparam int c_div   [c_n] = '{64, 64, 4, 3};
    localparam int c_db    [c_n] = '{8, 8, 5, 9};
    localparam int c_par   [c_n] = '{0, 2, 0, 1};
    localparam int c_stop  [c_n] = '{1, 2, 1, 2};
    localparam int c_depth [c_n] = '{4, 4, 2, 8};
    localparam int c_rate  [c_n] = '{2, 2, 20, 30};

    // Hand-derived first frames (bit k = k-th bit on the line) for the directed payloads.
    localparam logic [8:0]  c_dir   [c_n] = '{9'h06E, 9'h0A5, 9'h013, 9'h0A5};
    localparam logic [12:0] c_lit   [c_n] = '{13'b0001011011100, 13'b0110101001010,
                                              13'b0000001100110, 13'b1110101001010};
    localparam int          c_nbits [c_n] = '{10, 12, 7, 13};
    localparam int          c_flen  [c_n] = '{640, 768, 28, 39};

    logic           sys_clk = 1'b0;
    logic           rst_n   = 1'b0;
    logic [c_n-1:0] valid;
    logic [8:0]     data [c_n];
    wire  [c_n-1:0] ready_o;
    wire  [c_n-1:0] txd_o;
    wire  [c_n-1:0] idle_o;
    wire  [c_n-1:0] ok_o;
    wire  [7:0]     cnt_o [c_n];

    always #5 sys_clk = ~sys_clk;

    for (genvar g = 0; g < c_n; g++) begin : g_dut
        localparam int c_cw = $clog2(c_depth[g]) + 1;
        wire [c_cw-1:0] cnt_w;
        uart_tx_fifo #(
            .CLK_DIV   (c_div[g]),
            .DATA_BITS (c_db[g]),
            .PARITY    (c_par[g]),
            .STOP_BITS (c_stop[g]),
            .FIFO_DEPTH(c_depth[g])
        ) u_dut (
            .sys_clk   (sys_clk),
            .rst_n     (rst_n),
            .tx_valid  (valid[g]),
            .tx_data_i (data[g][c_db[g]-1:0]),
            .tx_ready  (ready_o[g]),
            .txd       (txd_o[g]),
            .tx_idle   (idle_o[g]),
            .tx_bits_ok(ok_o[g]),
            .fifo_count(cnt_w)
        );
        assign cnt_o[g] = 8'(cnt_w);
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL inst%0d %s: got %0h expected %0h at %0t", i, nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of pending payloads plus one frame in flight,
    // whose line level is looked up from the frame-bit definition.
    // ------------------------------------------------------------------
    int m_q    [c_n][16];
    int m_rd   [c_n];
    int m_cnt  [c_n];
    int m_t    [c_n];
    int m_cur  [c_n];
    bit m_busy [c_n];

    function automatic int flen(input int i);
        return (1 + c_db[i] + ((c_par[i] != 0) ? 1 : 0) + c_stop[i]) * c_div[i];
    endfunction

    function automatic bit frame_bit(input int i, input int d, input int k);
        int ones;
        if (k == 0) return 1'b0;
        if (k <= c_db[i]) return d[k-1];
        if (c_par[i] != 0 && k == c_db[i] + 1) begin
            ones = $countones(d);
            return (c_par[i] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
        return 1'b1;
    endfunction

    always @(posedge sys_clk) begin : p_model
        bit acc;
        bit start;
        for (int i = 0; i < c_n; i++) begin
            if (!rst_n) begin
                m_rd[i]   = 0;
                m_cnt[i]  = 0;
                m_t[i]    = 0;
                m_busy[i] = 1'b0;
            end else begin
                acc   = valid[i] && (m_cnt[i] < c_depth[i]);
                start = 1'b0;
                if (m_busy[i]) begin
                    if (m_t[i] == flen(i) - 1) begin
                        m_busy[i] = 1'b0;
                        start     = (m_cnt[i] > 0);
                    end else begin
                        m_t[i]++;
                    end
                end else begin
                    start = (m_cnt[i] > 0);
                end
                if (start) begin
                    m_cur[i]  = m_q[i][m_rd[i]];
                    m_rd[i]   = (m_rd[i] + 1) % 16;
                    m_cnt[i]--;
                    m_busy[i] = 1'b1;
                    m_t[i]    = 0;
                end
                if (acc) begin
                    m_q[i][(m_rd[i] + m_cnt[i]) % 16] = int'(data[i]) & ((1 << c_db[i]) - 1);
                    m_cnt[i]++;
                end
            end
        end
    end

    always @(negedge sys_clk) begin : p_compare
        if (chk_en) begin
            for (int i = 0; i < c_n; i++) begin
                check(i, "txd", 32'(txd_o[i]),
                      m_busy[i] ? 32'(frame_bit(i, m_cur[i], m_t[i] / c_div[i])) : 32'd1);
                check(i, "bits_ok", 32'(ok_o[i]), 32'(m_busy[i] && (m_t[i] == flen(i) - 1)));
                check(i, "idle", 32'(idle_o[i]), 32'(!m_busy[i] && (m_cnt[i] == 0)));
                check(i, "ready", 32'(ready_o[i]), 32'(m_cnt[i] < c_depth[i]));
                check(i, "count", 32'(cnt_o[i]), 32'(m_cnt[i]));
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(&idle_o) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        total++;
        if (!(&idle_o)) begin
            bad++;
            $display("FAIL drain: idle=%b expected all ones within %0d cycles", idle_o, budget);
        end
    endtask

    initial begin : p_stim
        logic [12:0] lit;
        int          noisy [c_n];

        valid = '0;
        for (int i = 0; i < c_n; i++) data[i] = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk_en = 1'b1;
        for (int i = 0; i < c_n; i++) begin
            check(i, "rst_txd", 32'(txd_o[i]), 32'd1);
            check(i, "rst_idle", 32'(idle_o[i]), 32'd1);
            check(i, "rst_ok", 32'(ok_o[i]), 32'd0);
            check(i, "rst_ready", 32'(ready_o[i]), 32'd1);
            check(i, "rst_count", 32'(cnt_o[i]), 32'd0);
        end
        rst_n = 1'b1;

        // Single directed frame per instance, checked bit-by-bit at mid-bit.
        for (int i = 0; i < c_n; i++) begin
            valid[i] = 1'b1;
            data[i]  = c_dir[i];
        end
        @(negedge sys_clk);
        valid = '0;
        for (int s = 0; s < 800; s++) begin
            @(negedge sys_clk);
            for (int i = 0; i < c_n; i++) begin
                lit = c_lit[i];
                if (s == 0) check(i, "latency_txd", 32'(txd_o[i]), 32'd0);
                for (int k = 0; k < c_nbits[i]; k++) begin
                    if (s == k * c_div[i] + c_div[i] / 2)
                        check(i, "lit_bit", 32'(txd_o[i]), 32'(lit[k]));
                end
                if (s == c_flen[i] - 2) check(i, "lit_ok_early", 32'(ok_o[i]), 32'd0);
                if (s == c_flen[i] - 1) check(i, "lit_ok", 32'(ok_o[i]), 32'd1);
                if (s == c_flen[i])     check(i, "lit_idle", 32'(idle_o[i]), 32'd1);
            end
        end

        // Seven consecutive writes: one is popped at once, the FIFO fills, the rest wait.
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < c_n; i++) begin
                valid[i] = 1'b1;
                data[i]  = 9'($urandom);
            end
            @(negedge sys_clk);
        end
        check(0, "burst_count", 32'(cnt_o[0]), 32'd4);
        check(0, "burst_ready", 32'(ready_o[0]), 32'd0);
        valid = '0;
        wait_idle(10000);

        // Random traffic, including writes while full.
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < c_n; i++) begin
                valid[i] = ($urandom_range(0, 99) < c_rate[i]);
                data[i]  = 9'($urandom);
            end
            @(negedge sys_clk);
        end
        valid = '0;
        wait_idle(20000);

        // Queue three frames, then reset part-way through the first one.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < c_n; i++) begin
                valid[i] = 1'b1;
                data[i]  = 9'($urandom);
            end
            @(negedge sys_clk);
        end
        valid = '0;
        repeat (298) @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < c_n; i++) begin
            check(i, "abort_txd", 32'(txd_o[i]), 32'd1);
            check(i, "abort_count", 32'(cnt_o[i]), 32'd0);
            check(i, "abort_idle", 32'(idle_o[i]), 32'd1);
            noisy[i] = 0;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge sys_clk);
            for (int i = 0; i < c_n; i++) begin
                if (txd_o[i] !== 1'b1) noisy[i]++;
            end
        end
        for (int i = 0; i < c_n; i++) check(i, "quiet_after_reset", 32'(noisy[i]), 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
